// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider op codes, divider FSM encoding, latency.
package cpu_defs_pkg;

    // Divider op select (funct3[1:0])
    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    // Divider FSM state encoding
    localparam logic [1:0] DIV_ST_IDLE   = 2'd0;
    localparam logic [1:0] DIV_ST_CALC   = 2'd1;
    localparam logic [1:0] DIV_ST_FINISH = 2'd2;

    // Edges from accepting START to registering RESULT
    localparam int DIV_LATENCY = 34;

endpackage

// File: rtl/div_step_32bit.sv
// One restoring-division iteration: shift {rem, quo} left and try to subtract.
module div_step_32bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // The shifted remainder can reach 2^WIDTH, so the trial is one bit wider.
    // When it does, the subtraction always succeeds and the result fits again.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[WIDTH-1:0];
            quo_nxt = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider_32bit.sv
// RV32M DIV/DIVU/REM/REMU unit: one quotient bit per cycle, fixed 34-edge latency.
module divider_32bit
    import cpu_defs_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             KILL,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [1:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       op_q,      op_d;
    logic [WIDTH-1:0] rem_q,     rem_d;
    logic [WIDTH-1:0] quo_q,     quo_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] data1_q,   data1_d;
    logic             qsign_q,   qsign_d;
    logic             rsign_q,   rsign_d;
    logic             dz_q,      dz_d;
    logic             ovf_q,     ovf_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             done_q,    done_d;

    logic [WIDTH-1:0] step_rem, step_quo;
    logic             op_signed, op_is_rem;
    logic [WIDTH-1:0] abs1, abs2;

    div_step_32bit #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (divisor_q),
        .rem_nxt (step_rem),
        .quo_nxt (step_quo)
    );

    // Next-state logic: operand capture, iteration, result fix-up, abort
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        data1_d   = data1_q;
        qsign_d   = qsign_q;
        rsign_d   = rsign_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        result_d  = result_q;
        done_d    = 1'b0;

        op_signed = (OP == DIV_OP_DIV) || (OP == DIV_OP_REM);
        abs1      = (op_signed && DATA1[WIDTH-1]) ? -DATA1 : DATA1;
        abs2      = (op_signed && DATA2[WIDTH-1]) ? -DATA2 : DATA2;
        op_is_rem = (op_q == DIV_OP_REM) || (op_q == DIV_OP_REMU);

        case (state_q)
            DIV_ST_IDLE: begin
                if (START) begin
                    state_d   = DIV_ST_CALC;
                    cnt_d     = '0;
                    op_d      = OP;
                    rem_d     = '0;
                    quo_d     = abs1;
                    divisor_d = abs2;
                    data1_d   = DATA1;
                    qsign_d   = op_signed && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                    rsign_d   = op_signed && DATA1[WIDTH-1];
                    dz_d      = (DATA2 == '0);
                    ovf_d     = op_signed && (DATA1 == {1'b1, {(WIDTH-1){1'b0}}})
                                          && (DATA2 == '1);
                end
            end
            DIV_ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1))
                    state_d = DIV_ST_FINISH;
            end
            DIV_ST_FINISH: begin
                state_d = DIV_ST_IDLE;
                done_d  = 1'b1;
                if (dz_q)
                    result_d = op_is_rem ? data1_q : '1;
                else if (ovf_q)
                    result_d = op_is_rem ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
                else if (op_is_rem)
                    result_d = rsign_q ? -rem_q : rem_q;
                else
                    result_d = qsign_q ? -quo_q : quo_q;
            end
            default: state_d = DIV_ST_IDLE;
        endcase

        // Flush wins over everything, including a START in the same cycle
        if (KILL) begin
            state_d  = DIV_ST_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= DIV_ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            data1_q   <= '0;
            qsign_q   <= 1'b0;
            rsign_q   <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            data1_q   <= data1_d;
            qsign_q   <= qsign_d;
            rsign_q   <= rsign_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign RESULT = result_q;
    assign DONE   = done_q;
    assign BUSY   = (state_q == DIV_ST_CALC) || (state_q == DIV_ST_FINISH);

endmodule

// File: tb/tb_divider_32bit.sv
// Directed bench for divider_32bit: arithmetic cases, latency, flow control, reset.
module tb_divider_32bit;
    import cpu_defs_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] DATA1 = '0;
    logic [31:0] DATA2 = '0;
    logic        KILL = 1'b0;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;

    int tests = 0;
    int fails = 0;

    divider_32bit #(.WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
        .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present START for the accepting edge (edge 1), then scramble the operands.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        START = 1'b1; OP = op; DATA1 = a; DATA2 = b;
        @(posedge CLK); #1;
        START = 1'b0; OP = ~op; DATA1 = 32'hDEAD_BEEF; DATA2 = 32'h0BAD_F00D;
    endtask

    // Counts edges from edge 1 until DONE is seen, with a bound.
    task automatic wait_done(input int lat0, output int lat, output int busy_n);
        lat = lat0;
        busy_n = BUSY ? 1 : 0;
        while (!DONE && lat < 60) begin
            @(posedge CLK); #1;
            lat++;
            if (BUSY) busy_n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int lat, busy_n;
        issue(op, a, b);
        wait_done(1, lat, busy_n);
        chk({tag, " latency"}, 32'(lat), 32'(DIV_LATENCY));
        chk({tag, " result"}, RESULT, exp);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, " busy_in_done"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int lat, busy_n, done_cnt;
        logic [31:0] held;

        // Reset state
        #1;
        chk("rst busy", {31'd0, BUSY}, 32'd0);
        chk("rst done", {31'd0, DONE}, 32'd0);
        chk("rst result", RESULT, 32'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Unsigned
        run_op("divu 100/7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu 100/7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2);
        run_op("divu max/1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
        run_op("remu max/2^31", DIV_OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF);

        // Signed sign handling
        run_op("div -7/2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem -7/2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("div 7/-2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("rem 7/-2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);

        // Divide by zero and overflow (same latency)
        run_op("div 5/0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("remu x/0", DIV_OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run_op("rem -5/0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        run_op("div ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu no-ovf", DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // START mid-CALC is ignored
        issue(DIV_OP_DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge CLK); #1; end
        START = 1'b1; OP = DIV_OP_REMU; DATA1 = 32'd55; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0;
        wait_done(6, lat, busy_n);
        chk("midstart latency", 32'(lat), 32'd34);
        chk("midstart result", RESULT, 32'd14);

        // START in the DONE cycle: back-to-back (run_op returns in the DONE cycle)
        run_op("b2b div 1000/-10", DIV_OP_DIV, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C);

        // KILL on CALC cycle 10
        held = RESULT;
        issue(DIV_OP_DIVU, 32'd1000, 32'd3);
        repeat (9) begin @(posedge CLK); #1; end
        KILL = 1'b1;
        @(posedge CLK); #1;
        KILL = 1'b0;
        chk("kill busy", {31'd0, BUSY}, 32'd0);
        chk("kill result", RESULT, held);
        done_cnt = 0;
        repeat (40) begin
            @(posedge CLK); #1;
            if (DONE) done_cnt++;
        end
        chk("kill no done", 32'(done_cnt), 32'd0);
        chk("kill result held", RESULT, held);

        // KILL together with START wins
        START = 1'b1; KILL = 1'b1; OP = DIV_OP_DIVU; DATA1 = 32'd9; DATA2 = 32'd3;
        @(posedge CLK); #1;
        START = 1'b0; KILL = 1'b0;
        chk("kill+start busy", {31'd0, BUSY}, 32'd0);

        // Asynchronous reset mid-CALC
        run_op("pre-reset divu 77/7", DIV_OP_DIVU, 32'd77, 32'd7, 32'd11);
        issue(DIV_OP_DIVU, 32'd100, 32'd7);
        repeat (4) begin @(posedge CLK); #1; end
        #2;
        RESET = 1'b1;
        #1;
        chk("async rst busy", {31'd0, BUSY}, 32'd0);
        chk("async rst done", {31'd0, DONE}, 32'd0);
        chk("async rst result", RESULT, 32'd0);
        #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        run_op("post-reset rem -100/7", DIV_OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
